// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rds_state_t;

  localparam int RDS_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry FIFO-order buffer between the FIFO read port and the output stream.
module fifo_skid2
  import fifo_rd_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [DT_WIDTH-1:0] din,
  output logic [DT_WIDTH-1:0] dout,
  output logic [1:0]          cnt
);

  logic [DT_WIDTH-1:0] mem_q [RDS_BUF_DEPTH];
  logic [DT_WIDTH-1:0] mem_d [RDS_BUF_DEPTH];
  logic                head_q, head_d;
  logic                tail_q, tail_d;
  logic [1:0]          cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[tail_q] = din;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so the stream data reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RDS_BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = mem_q[head_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine: pops the sync FIFO into a 2-entry buffer and presents a valid/ready stream.
//   state | meaning
//   IDLE  | no FIFO pops; buffered words (if any) still drain to the output
//   RUN   | pop whenever the FIFO has data and the buffer has room
//   DRAIN | keep popping until FIFO and buffer are both empty; run ignored
//   DONE  | one-cycle drain_done pulse, then back to IDLE
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DT_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 f_empty,
  input  logic [DT_WIDTH-1:0]  rd_dt,
  output logic                 rd_en,
  output logic [DT_WIDTH-1:0]  out_dt,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 drain_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  rds_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [1:0]           buf_cnt;
  logic                 en;
  logic                 hs;

  fifo_skid2 #(.DT_WIDTH(DT_WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (rd_en),
    .pop  (hs),
    .din  (rd_dt),
    .dout (out_dt),
    .cnt  (buf_cnt)
  );

  // rd_en deliberately ignores out_rdy so the FIFO side never waits on the consumer combinationally.
  always_comb begin
    en      = (state_q == RUN) || (state_q == DRAIN);
    rd_en   = en && !f_empty && (buf_cnt < 2'(RDS_BUF_DEPTH));
    out_vld = (buf_cnt != 2'd0);
    hs      = out_vld && out_rdy;
  end

  always_comb begin
    state_d    = state_q;
    xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(hs);
    case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (!run) state_d = DRAIN;
      DRAIN:   if (f_empty && (buf_cnt == 2'd0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign drain_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side engine for the team's synchronous FIFO (`syncfifo`). It pops words from the FIFO read port using `rd_en`/`f_empty`/`rd_dt`, and re-presents them on a registered valid/ready output stream through a 2-entry buffer. It supports an explicit run/drain sequence and counts delivered words. It sits between the FIFO and any downstream consumer that applies backpressure.

## Interface
- `DT_WIDTH`, 8, data word width; must match the FIFO.
- `CNT_WIDTH`, 16, width of the delivered-word counter.
- `clk  in  1  clock, all logic on rising edge`
- `rst  in  1  synchronous reset, active-high`
- `run  in  1  level; 1 = consume from FIFO; falling edge starts a drain`
- `f_empty  in  1  FIFO empty flag`
- `rd_dt  in  DT_WIDTH  FIFO read data, valid in the same cycle as rd_en & !f_empty`
- `rd_en  out  1  FIFO pop request; combinational`
- `out_dt  out  DT_WIDTH  stream data`
- `out_vld  out  1  stream valid`
- `out_rdy  in  1  stream ready from consumer`
- `drain_done  out  1  one-cycle pulse when a drain completes`
- `busy  out  1  state != IDLE`
- `xfer_cnt  out  CNT_WIDTH  number of completed output handshakes, wraps`

## Operation
- FIFO read semantics:
  - `rd_dt` is combinational and valid while `rd_en & !f_empty`.
  - The FIFO pointer advances at the next edge.
  - A pop is therefore captured into the buffer at the same edge it is issued.
- `rd_en = en & !f_empty & (buf_cnt < 2)`.
  - `en` is 1 in RUN and DRAIN.
  - There is no path from `out_rdy` to `rd_en`.
- Buffer:
  - 2 entries, head/tail 1-bit pointers, `buf_cnt` ranges 0..2.
  - Push when `rd_en`; pop when `out_vld & out_rdy`.
  - Push and pop in the same cycle leave `buf_cnt` unchanged.
- Output: `out_vld = (buf_cnt != 0)`, `out_dt = buf[head]`.
  - `out_dt` is held stable while `out_vld & !out_rdy`.
- `xfer_cnt` increments by 1 on every output handshake and wraps from 2^CNT_WIDTH-1 to 0.
- State machine:
  - IDLE: `rd_en` is 0. Go to RUN when `run=1`. Buffered words still drain to the output.
  - RUN: pops as allowed. Go to DRAIN when `run=0`.
  - DRAIN: pops continue. Go to DONE when `f_empty=1` and `buf_cnt=0` in the same cycle. `run` is ignored in this state.
  - DONE: `drain_done=1` for this one cycle, then go to IDLE unconditionally.
- Boundary behaviour:
  - FIFO empty in RUN: no pop, stay in RUN.
  - Buffer full and `out_rdy=0`: `rd_en=0`, FIFO untouched.
  - `run` reasserted during DRAIN or DONE: takes effect once back in IDLE.
  - `run` high for exactly one cycle: IDLE → RUN → DRAIN. Any pop in RUN completes normally.
  - Reset mid-operation: buffer contents are discarded. The FIFO shares `rst`, so no word is double-delivered.

## Timing
- Reset values:
  - state = IDLE
  - `rd_en=0`, `out_vld=0`, `out_dt=0`
  - `drain_done=0`, `busy=0`, `xfer_cnt=0`
  - `buf_cnt=0`, pointers = 0
- Latency:
  - Word popped at edge N is on `out_dt` with `out_vld=1` in cycle N+1.
  - First pop occurs in the cycle after `run` is sampled high (the IDLE→RUN edge).
- Throughput: 1 word/cycle sustained with `out_rdy=1` and a non-empty FIFO; `buf_cnt` stays at 1.
- Backpressure: at most 2 words are in flight in the buffer. Refill resumes in the cycle after a pop frees a slot.
- `drain_done` rises exactly 1 cycle after the edge where the FIFO and buffer are both empty in DRAIN.
- `busy` falls in the same cycle `drain_done` falls.

## Structure
- `fifo_rd_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rds_state_t;`
  - buffer depth constant `RDS_BUF_DEPTH = 2`.
- Sub-module `fifo_skid2`:
  - 2-entry buffer with `push`/`pop`/`din`/`dout`/`cnt`, parameterised by `DT_WIDTH`.
  - Contains no FSM.
- The top level holds the FSM, `rd_en` gating and `xfer_cnt`.
- The bench instantiates this block together with `syncfifo`, `F_DEPTH=16`, `DT_WIDTH=8`.

## Test plan
- Reset then idle:
  - Stimulus: write 0x11, 0x22, 0x33 to the FIFO, keep `run=0` for 5 cycles.
  - Required: `rd_en=0`, `out_vld=0`, `xfer_cnt=0`, FIFO still holds 3 words.
- Streaming:
  - Stimulus: FIFO holds 0x01..0x10, `run=1`, `out_rdy=1`.
  - Required: 16 consecutive cycles with `out_vld=1` and `out_dt` = 0x01..0x10 in order, `xfer_cnt=16`.
- Backpressure:
  - Stimulus: FIFO holds 0xA0..0xA4, `out_rdy=0` for 6 cycles, then 1.
  - Required: exactly 2 pops issued, then `rd_en=0`. `out_dt=0xA0` is held stable throughout the stall. The output sequence continues 0xA0..0xA4 with no loss.
- Drain:
  - Stimulus: FIFO holds 4 words, `run` pulses high for 1 cycle, `out_rdy=1`.
  - Required: all 4 words are delivered. `drain_done` pulses once, 1 cycle after empty. Then `busy=0` and state is IDLE.
- Reset mid-stream:
  - Stimulus: assert `rst` while `buf_cnt=2` and the FIFO is non-empty.
  - Required: the next cycle has `out_vld=0`, `xfer_cnt=0`, `rd_en=0`, state IDLE.
- Counter wrap:
  - Stimulus: `CNT_WIDTH=4`, stream 17 words.
  - Required: `xfer_cnt` reads 0 after the 16th handshake and 1 after the 17th.
